axi_txn_sig_scoreboard: RTL and testbench



---
 rtl/axi_txn_sig_pkg.sv | 30 +++
 rtl/axi_txn_sig_capture.sv | 139 +++++++++++++
 rtl/axi_txn_sig_scoreboard.sv | 119 +++++++++++
 tb/tb_axi_txn_sig_scoreboard.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_txn_sig_pkg.sv
// axi_txn_sig_pkg
//   Shared types and helpers for the AXI write-path signature scoreboard.
//   sig_rec_t : one reduced transaction {addr, len, data_sig, beats}
//   fold32()  : XOR of all 32-bit slices of a data word
//   The record address field is sized for the widest supported ADDR_W and
//   the fold input for the widest supported DATA_W; narrower users
//   zero-extend, which leaves both the compare and the fold unchanged.
package axi_txn_sig_pkg;

    localparam int SIG_W      = 32;
    localparam int MAX_ADDR_W = 64;
    localparam int MAX_DATA_W = 1024;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [SIG_W-1:0]      data_sig;
        logic [8:0]            beats;
    } sig_rec_t;

    function automatic logic [SIG_W-1:0] fold32(input logic [MAX_DATA_W-1:0] data);
        logic [SIG_W-1:0] f;
        f = '0;
        for (int i = 0; i < MAX_DATA_W / SIG_W; i++) begin
            f = f ^ data[i*SIG_W +: SIG_W];
        end
        return f;
    endfunction

endpackage

// File: rtl/axi_txn_sig_capture.sv
// axi_txn_sig_capture
//   Passive tap of one AXI write interface. Reduces each transaction to a
//   sig_rec_t and queues it for the in-order comparator.
//   Inputs : aclk, aresetn (sync, active low), clr (sync clear),
//            AW tap (awvalid/awready/awaddr/awlen),
//            W tap (wvalid/wready/wlast/wdata), rec_pop from comparator.
//   Outputs: rec_valid/rec (head record, fall-through), overflow (sticky),
//            len_err (sticky), empty (no queued state, no partial signature).
module axi_txn_sig_capture
    import axi_txn_sig_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              clr,
    input  logic              awvalid,
    input  logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic              wvalid,
    input  logic              wready,
    input  logic              wlast,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rec_pop,
    output logic              rec_valid,
    output sig_rec_t          rec,
    output logic              overflow,
    output logic              len_err,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic rst;
    assign rst = !aresetn || clr;

    logic             aw_hs, w_hs, last_hs;
    logic [SIG_W-1:0] acc, acc_next;
    logic [8:0]       beats;

    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign last_hs  = w_hs && wlast;
    assign acc_next = {acc[SIG_W-2:0], acc[SIG_W-1]} ^ fold32(MAX_DATA_W'(wdata));

    logic [ADDR_W-1:0] cmd_addr_mem [DEPTH];
    logic [7:0]        cmd_len_mem  [DEPTH];
    logic [PW-1:0]     cmd_wp, cmd_rp;
    logic [PW:0]       cmd_cnt;

    logic [SIG_W-1:0]  dsig_sig_mem   [DEPTH];
    logic [8:0]        dsig_beats_mem [DEPTH];
    logic [PW-1:0]     dsig_wp, dsig_rp;
    logic [PW:0]       dsig_cnt;

    sig_rec_t          rec_mem [DEPTH];
    logic [PW-1:0]     rec_wp, rec_rp;
    logic [PW:0]       rec_cnt;

    logic     do_join, cmd_push, dsig_push, cmd_drop, dsig_drop;
    logic     rec_store, rec_take, beats_bad;
    sig_rec_t join_rec;

    assign do_join = (cmd_cnt != '0) && (dsig_cnt != '0) && (rec_cnt != FULL_CNT);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign cmd_push  = aw_hs && ((cmd_cnt != FULL_CNT) || do_join);
    assign cmd_drop  = aw_hs && !cmd_push;
    assign dsig_push = last_hs && ((dsig_cnt != FULL_CNT) || do_join);
    assign dsig_drop = last_hs && !dsig_push;

    assign join_rec = '{addr:     MAX_ADDR_W'(cmd_addr_mem[cmd_rp]),
                        len:      cmd_len_mem[cmd_rp],
                        data_sig: dsig_sig_mem[dsig_rp],
                        beats:    dsig_beats_mem[dsig_rp]};
    assign beats_bad = dsig_beats_mem[dsig_rp] != ({1'b0, cmd_len_mem[cmd_rp]} + 9'd1);

    // Record FIFO is fall-through: a freshly joined record is offered to the
    // comparator in the join cycle and only stored if it is not consumed.
    assign rec_valid = (rec_cnt != '0) || do_join;
    assign rec       = (rec_cnt != '0) ? rec_mem[rec_rp] : join_rec;
    assign rec_take  = rec_pop && (rec_cnt != '0);
    assign rec_store = do_join && !((rec_cnt == '0) && rec_pop);

    assign empty = (cmd_cnt == '0) && (dsig_cnt == '0) && (rec_cnt == '0) && (beats == '0);

    always_ff @(posedge aclk) begin
        if (cmd_push) begin
            cmd_addr_mem[cmd_wp] <= awaddr;
            cmd_len_mem[cmd_wp]  <= awlen;
        end
        if (dsig_push) begin
            dsig_sig_mem[dsig_wp]   <= acc_next;
            dsig_beats_mem[dsig_wp] <= beats + 9'd1;
        end
        if (rec_store) begin
            rec_mem[rec_wp] <= join_rec;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            acc      <= '0;
            beats    <= '0;
            cmd_wp   <= '0;
            cmd_rp   <= '0;
            cmd_cnt  <= '0;
            dsig_wp  <= '0;
            dsig_rp  <= '0;
            dsig_cnt <= '0;
            rec_wp   <= '0;
            rec_rp   <= '0;
            rec_cnt  <= '0;
            overflow <= 1'b0;
            len_err  <= 1'b0;
        end else begin
            if (w_hs) begin
                acc   <= wlast ? '0 : acc_next;
                beats <= wlast ? '0 : beats + 9'd1;
            end
            if (cmd_push)  cmd_wp  <= cmd_wp + PW'(1);
            if (do_join)   cmd_rp  <= cmd_rp + PW'(1);
            if (dsig_push) dsig_wp <= dsig_wp + PW'(1);
            if (do_join)   dsig_rp <= dsig_rp + PW'(1);
            if (rec_store) rec_wp  <= rec_wp + PW'(1);
            if (rec_take)  rec_rp  <= rec_rp + PW'(1);
            cmd_cnt  <= cmd_cnt + (PW+1)'(cmd_push) - (PW+1)'(do_join);
            dsig_cnt <= dsig_cnt + (PW+1)'(dsig_push) - (PW+1)'(do_join);
            rec_cnt  <= rec_cnt + (PW+1)'(rec_store) - (PW+1)'(rec_take);
            if (cmd_drop || dsig_drop) overflow <= 1'b1;
            if (do_join && beats_bad)  len_err  <= 1'b1;
        end
    end

endmodule

// File: rtl/axi_txn_sig_scoreboard.sv
// axi_txn_sig_scoreboard
//   In-order signature scoreboard for one AXI write path. Two passive
//   capture taps (u_* upstream, d_* downstream) feed an in-order comparator.
//   Inputs : aclk, aresetn (sync, active low), clr (sync clear),
//            u_aw*/u_w* and d_aw*/d_w* tap signals.
//   Outputs: pass_cnt/fail_cnt (saturating), mismatch (sticky),
//            first_fail_addr, overflow (sticky), len_err (sticky), idle.
//   Optional: define AXI_TXN_SIG_SCOREBOARD_TIMEOUT_EN to add the sticky
//            timeout output and its watchdog (limit TIMEOUT cycles).
module axi_txn_sig_scoreboard
    import axi_txn_sig_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              clr,
    input  logic              u_awvalid,
    input  logic              u_awready,
    input  logic [ADDR_W-1:0] u_awaddr,
    input  logic [7:0]        u_awlen,
    input  logic              u_wvalid,
    input  logic              u_wready,
    input  logic              u_wlast,
    input  logic [DATA_W-1:0] u_wdata,
    input  logic              d_awvalid,
    input  logic              d_awready,
    input  logic [ADDR_W-1:0] d_awaddr,
    input  logic [7:0]        d_awlen,
    input  logic              d_wvalid,
    input  logic              d_wready,
    input  logic              d_wlast,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              mismatch,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic              overflow,
    output logic              len_err,
    output logic              idle
`ifdef AXI_TXN_SIG_SCOREBOARD_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    if (DATA_W % SIG_W != 0 || DATA_W > MAX_DATA_W || ADDR_W > MAX_ADDR_W ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("axi_txn_sig_scoreboard: illegal parameter set");
    end

    logic     rst;
    logic     u_rec_valid, d_rec_valid, u_ovf, d_ovf, u_len_err, d_len_err, u_empty, d_empty;
    sig_rec_t u_rec, d_rec;
    logic     cmp;

    assign rst = !aresetn || clr;
    assign cmp = u_rec_valid && d_rec_valid;

    axi_txn_sig_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_cap (
        .aclk(aclk), .aresetn(aresetn), .clr(clr),
        .awvalid(u_awvalid), .awready(u_awready), .awaddr(u_awaddr), .awlen(u_awlen),
        .wvalid(u_wvalid), .wready(u_wready), .wlast(u_wlast), .wdata(u_wdata),
        .rec_pop(cmp), .rec_valid(u_rec_valid), .rec(u_rec),
        .overflow(u_ovf), .len_err(u_len_err), .empty(u_empty)
    );

    axi_txn_sig_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) d_cap (
        .aclk(aclk), .aresetn(aresetn), .clr(clr),
        .awvalid(d_awvalid), .awready(d_awready), .awaddr(d_awaddr), .awlen(d_awlen),
        .wvalid(d_wvalid), .wready(d_wready), .wlast(d_wlast), .wdata(d_wdata),
        .rec_pop(cmp), .rec_valid(d_rec_valid), .rec(d_rec),
        .overflow(d_ovf), .len_err(d_len_err), .empty(d_empty)
    );

    assign overflow = u_ovf || d_ovf;
    assign len_err  = u_len_err || d_len_err;
    assign idle     = u_empty && d_empty;

    always_ff @(posedge aclk) begin
        if (rst) begin
            pass_cnt        <= '0;
            fail_cnt        <= '0;
            mismatch        <= 1'b0;
            first_fail_addr <= '0;
        end else if (cmp) begin
            if (u_rec == d_rec) begin
                if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                mismatch <= 1'b1;
                if (!mismatch) first_fail_addr <= u_rec.addr[ADDR_W-1:0];
            end
        end
    end

`ifdef AXI_TXN_SIG_SCOREBOARD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;

    // Runs only while exactly one side has a record waiting for its partner.
    always_ff @(posedge aclk) begin
        if (rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else if (cmp || (!u_rec_valid && !d_rec_valid)) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_W'(TIMEOUT)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_cnt == WD_W'(TIMEOUT - 1)) timeout <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_txn_sig_scoreboard.sv
module tb_axi_txn_sig_scoreboard;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 16;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              clr = 1'b0;
    logic              u_awvalid = 1'b0, u_awready = 1'b1;
    logic [ADDR_W-1:0] u_awaddr = '0;
    logic [7:0]        u_awlen = '0;
    logic              u_wvalid = 1'b0, u_wready = 1'b1, u_wlast = 1'b0;
    logic [DATA_W-1:0] u_wdata = '0;
    logic              d_awvalid = 1'b0, d_awready = 1'b1;
    logic [ADDR_W-1:0] d_awaddr = '0;
    logic [7:0]        d_awlen = '0;
    logic              d_wvalid = 1'b0, d_wready = 1'b1, d_wlast = 1'b0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [CNT_W-1:0]  pass_cnt, fail_cnt;
    logic              mismatch, overflow, len_err, idle;
    logic [ADDR_W-1:0] first_fail_addr;
`ifdef AXI_TXN_SIG_SCOREBOARD_TIMEOUT_EN
    logic              timeout;
`endif

    int errors = 0;
    int checks = 0;

    axi_txn_sig_scoreboard #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .clr(clr),
        .u_awvalid(u_awvalid), .u_awready(u_awready), .u_awaddr(u_awaddr), .u_awlen(u_awlen),
        .u_wvalid(u_wvalid), .u_wready(u_wready), .u_wlast(u_wlast), .u_wdata(u_wdata),
        .d_awvalid(d_awvalid), .d_awready(d_awready), .d_awaddr(d_awaddr), .d_awlen(d_awlen),
        .d_wvalid(d_wvalid), .d_wready(d_wready), .d_wlast(d_wlast), .d_wdata(d_wdata),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .mismatch(mismatch),
        .first_fail_addr(first_fail_addr), .overflow(overflow), .len_err(len_err), .idle(idle)
`ifdef AXI_TXN_SIG_SCOREBOARD_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All drive tasks start and end on a falling edge.
    task automatic pulse_rst(input bit use_clr);
        if (use_clr) clr = 1'b1; else aresetn = 1'b0;
        @(negedge aclk);
        clr     = 1'b0;
        aresetn = 1'b1;
    endtask

    task automatic aw(input bit side, input logic [ADDR_W-1:0] addr, input logic [7:0] len);
        if (!side) begin u_awvalid = 1'b1; u_awaddr = addr; u_awlen = len; end
        else       begin d_awvalid = 1'b1; d_awaddr = addr; d_awlen = len; end
        @(negedge aclk);
        if (!side) u_awvalid = 1'b0; else d_awvalid = 1'b0;
    endtask

    task automatic wbeat(input bit side, input logic [DATA_W-1:0] data, input bit last);
        if (!side) begin u_wvalid = 1'b1; u_wdata = data; u_wlast = last; end
        else       begin d_wvalid = 1'b1; d_wdata = data; d_wlast = last; end
        @(negedge aclk);
        if (!side) begin u_wvalid = 1'b0; u_wlast = 1'b0; end
        else       begin d_wvalid = 1'b0; d_wlast = 1'b0; end
    endtask

    // Beat i carries base+i, except beat bad which carries 0xFF.
    task automatic write_txn(input bit side, input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                             input int nbeats, input int bad, input int base);
        aw(side, addr, len);
        for (int i = 0; i < nbeats; i++)
            wbeat(side, (i == bad) ? 64'hFF : 64'(base + i), i == nbeats - 1);
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_pass"}, 64'(pass_cnt), 64'd0);
        check_val({tag, "_fail"}, 64'(fail_cnt), 64'd0);
        check_val({tag, "_mismatch"}, 64'(mismatch), 64'd0);
        check_val({tag, "_ffa"}, 64'(first_fail_addr), 64'd0);
        check_val({tag, "_overflow"}, 64'(overflow), 64'd0);
        check_val({tag, "_len_err"}, 64'(len_err), 64'd0);
        check_val({tag, "_idle"}, 64'(idle), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge aclk);
        pulse_rst(1'b0);
        check_cleared("reset");

        // identical write on both sides; counters move exactly one edge after the join
        fork
            write_txn(1'b0, 32'h1000, 8'd3, 4, -1, 1);
            write_txn(1'b1, 32'h1000, 8'd3, 4, -1, 1);
        join
        check_val("t1_not_early", 64'(pass_cnt), 64'd0);
        @(negedge aclk);
        check_val("t1_pass", 64'(pass_cnt), 64'd1);
        check_val("t1_fail", 64'(fail_cnt), 64'd0);
        check_val("t1_idle", 64'(idle), 64'd1);

        // corrupted downstream beat, then a good write
        pulse_rst(1'b1);
        fork
            write_txn(1'b0, 32'h1000, 8'd3, 4, -1, 1);
            write_txn(1'b1, 32'h1000, 8'd3, 4, 1, 1);
        join
        @(negedge aclk);
        check_val("t2_fail", 64'(fail_cnt), 64'd1);
        check_val("t2_mismatch", 64'(mismatch), 64'd1);
        check_val("t2_ffa", 64'(first_fail_addr), 64'h1000);
        fork
            write_txn(1'b0, 32'h2000, 8'd3, 4, -1, 5);
            write_txn(1'b1, 32'h2000, 8'd3, 4, -1, 5);
        join
        @(negedge aclk);
        check_val("t2_pass_after", 64'(pass_cnt), 64'd1);
        check_val("t2_fail_after", 64'(fail_cnt), 64'd1);
        check_val("t2_ffa_kept", 64'(first_fail_addr), 64'h1000);

        // upstream W leads its AW by 5 cycles; upper data slice folds onto the lower
        pulse_rst(1'b0);
        fork
            begin
                wbeat(1'b0, 64'h0000_0001_0000_0000, 1'b0);
                wbeat(1'b0, 64'd2, 1'b1);
                repeat (5) @(negedge aclk);
                aw(1'b0, 32'h3000, 8'd1);
            end
            write_txn(1'b1, 32'h3000, 8'd1, 2, -1, 1);
        join
        repeat (2) @(negedge aclk);
        check_val("t3_pass", 64'(pass_cnt), 64'd1);
        check_val("t3_fail", 64'(fail_cnt), 64'd0);
        check_val("t3_len_err", 64'(len_err), 64'd0);

        // DEPTH+1 upstream AWs before any W: the last one is dropped
        pulse_rst(1'b1);
        for (int i = 0; i <= DEPTH; i++) aw(1'b0, 32'h4000 + 32'(i * 16), 8'd0);
        check_val("t4_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i <= DEPTH; i++) wbeat(1'b0, 64'(i + 1), 1'b1);
        repeat (2) @(negedge aclk);
        check_val("t4_pass_none", 64'(pass_cnt), 64'd0);
        for (int i = 0; i < DEPTH; i++) write_txn(1'b1, 32'h4000 + 32'(i * 16), 8'd0, 1, -1, i + 1);
        repeat (2) @(negedge aclk);
        check_val("t4_pass", 64'(pass_cnt), 64'(DEPTH));
        check_val("t4_fail", 64'(fail_cnt), 64'd0);
        check_val("t4_leftover_not_idle", 64'(idle), 64'd0);

        // short burst on both sides, then reset in the middle of a burst
        pulse_rst(1'b0);
        fork
            write_txn(1'b0, 32'h5000, 8'd3, 3, -1, 1);
            write_txn(1'b1, 32'h5000, 8'd3, 3, -1, 1);
        join
        repeat (2) @(negedge aclk);
        check_val("t5_len_err", 64'(len_err), 64'd1);
        check_val("t5_pass", 64'(pass_cnt), 64'd1);
        wbeat(1'b0, 64'hAA, 1'b0);
        wbeat(1'b0, 64'hBB, 1'b0);
        check_val("t5_partial_not_idle", 64'(idle), 64'd0);
        pulse_rst(1'b0);
        check_cleared("t5_midburst_reset");
        // a beat without ready must not be counted
        u_wvalid = 1'b1; u_wready = 1'b0; u_wdata = 64'h55; u_wlast = 1'b1;
        @(negedge aclk);
        u_wvalid = 1'b0; u_wready = 1'b1; u_wlast = 1'b0;
        fork
            write_txn(1'b0, 32'h6000, 8'd1, 2, -1, 7);
            write_txn(1'b1, 32'h6000, 8'd1, 2, -1, 7);
        join
        repeat (2) @(negedge aclk);
        check_val("t5_fresh_pass", 64'(pass_cnt), 64'd1);
        check_val("t5_fresh_fail", 64'(fail_cnt), 64'd0);

`ifdef AXI_TXN_SIG_SCOREBOARD_TIMEOUT_EN
        pulse_rst(1'b1);
        check_val("t6_timeout_reset", 64'(timeout), 64'd0);
        write_txn(1'b0, 32'h7000, 8'd0, 1, -1, 1);
        repeat (15) @(negedge aclk);
        check_val("t6_timeout_early", 64'(timeout), 64'd0);
        @(negedge aclk);
        check_val("t6_timeout_set", 64'(timeout), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
